// File: rtl/squat_arb_pkg.sv
// Shared types and constants for the Utopia Rx/Tx cell schedulers.
package squat_arb_pkg;

    localparam int unsigned CELL_BYTES = 53;
    localparam int unsigned PORT_ID_W  = 4;
    localparam int unsigned BYTE_IDX_W = 6;

    typedef logic [PORT_ID_W-1:0]  port_id_t;
    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XFER,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first eligible bit at or above ptr_i,
// wrapping modulo N. Shared by the Rx and Tx schedulers.
module rr_pick
    import squat_arb_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] eligible_i,
    input  port_id_t     ptr_i,
    output logic [N-1:0] onehot_o,
    output port_id_t     index_o,
    output logic         any_o
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % N);
            if (!found && eligible_i[cand]) begin
                found          = 1'b1;
                index_o        = port_id_t'(cand);
                onehot_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/utopia_rx_arbiter.sv
// Round-robin scheduler pacing one cell at a time from the Utopia Rx ports.
// Optional stall watchdog: define UTOPIA_ARB_WATCHDOG_EN.
module utopia_rx_arbiter
    import squat_arb_pkg::*;
#(
    parameter int unsigned NumRx     = 16,
    parameter int unsigned CellBytes = CELL_BYTES
`ifdef UTOPIA_ARB_WATCHDOG_EN
    ,
    parameter int unsigned TimeoutCycles = 1024
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumRx-1:0] req_i,
    input  logic [NumRx-1:0] port_en_i,
    input  logic             xfer_ack_i,
    output logic [NumRx-1:0] grant_o,
    output port_id_t         grant_id_o,
    output logic             grant_valid_o,
    output byte_idx_t        byte_idx_o,
    output logic             cell_done_o,
    output logic             timeout_err_o
);

    localparam byte_idx_t LastByte = byte_idx_t'(CellBytes - 1);
    localparam port_id_t  LastPort = port_id_t'(NumRx - 1);

    arb_state_t       state_q;
    logic [NumRx-1:0] grant_q;
    port_id_t         grant_id_q;
    port_id_t         ptr_q;
    logic             grant_valid_q;
    byte_idx_t        byte_idx_q;
    logic             cell_done_q;

    logic [NumRx-1:0] eligible;
    logic [NumRx-1:0] pick_onehot;
    port_id_t         pick_id;
    logic             pick_any;
    port_id_t         ptr_next;

    assign eligible = req_i & port_en_i;
    assign ptr_next = (grant_id_q == LastPort) ? '0 : grant_id_q + port_id_t'(1);

    rr_pick #(
        .N (NumRx)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .onehot_o   (pick_onehot),
        .index_o    (pick_id),
        .any_o      (pick_any)
    );

`ifdef UTOPIA_ARB_WATCHDOG_EN
    localparam int unsigned      StallW    = $clog2(TimeoutCycles);
    localparam logic [StallW-1:0] StallLast = StallW'(TimeoutCycles - 1);

    logic [StallW-1:0] stall_q;
    logic              timeout_err_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            ptr_q         <= '0;
            grant_valid_q <= 1'b0;
            byte_idx_q    <= '0;
            cell_done_q   <= 1'b0;
`ifdef UTOPIA_ARB_WATCHDOG_EN
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            cell_done_q <= 1'b0;
`ifdef UTOPIA_ARB_WATCHDOG_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q       <= pick_onehot;
                        grant_id_q    <= pick_id;
                        grant_valid_q <= 1'b1;
                        byte_idx_q    <= '0;
                        state_q       <= GRANT;
                    end
                end
                GRANT: begin
                    // One setup cycle for the datapath mux before bytes move.
                    state_q <= XFER;
`ifdef UTOPIA_ARB_WATCHDOG_EN
                    stall_q <= '0;
`endif
                end
                XFER: begin
                    if (xfer_ack_i) begin
`ifdef UTOPIA_ARB_WATCHDOG_EN
                        stall_q <= '0;
`endif
                        if (byte_idx_q == LastByte) begin
                            state_q       <= DONE;
                            cell_done_q   <= 1'b1;
                            grant_q       <= '0;
                            grant_valid_q <= 1'b0;
                            byte_idx_q    <= '0;
                        end else begin
                            byte_idx_q <= byte_idx_q + byte_idx_t'(1);
                        end
                    end
`ifdef UTOPIA_ARB_WATCHDOG_EN
                    // Abort a stalled cell and skip past the stuck port.
                    else if (stall_q == StallLast) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        byte_idx_q    <= '0;
                        ptr_q         <= ptr_next;
                    end else begin
                        stall_q <= stall_q + StallW'(1);
                    end
`endif
                end
                DONE: begin
                    ptr_q   <= ptr_next;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = grant_id_q;
    assign grant_valid_o = grant_valid_q;
    assign byte_idx_o    = byte_idx_q;
    assign cell_done_o   = cell_done_q;
`ifdef UTOPIA_ARB_WATCHDOG_EN
    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_utopia_rx_arbiter.sv
// Self-checking bench for utopia_rx_arbiter: cell-level reference model plus
// directed scenarios (reset abort, single port, fairness, masking, stall, watchdog).
module tb_utopia_rx_arbiter;

    localparam int NRX = 16;
    localparam int CB  = 53;
`ifdef UTOPIA_ARB_WATCHDOG_EN
    localparam int TO = 16;
`else
    localparam int TO = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] en;
    logic        ack;
    logic [15:0] grant;
    logic [3:0]  gid;
    logic        gvalid;
    logic [5:0]  bidx;
    logic        cdone;
    logic        terr;

`ifdef UTOPIA_ARB_WATCHDOG_EN
    utopia_rx_arbiter #(.NumRx(NRX), .CellBytes(CB), .TimeoutCycles(TO)) dut (
`else
    utopia_rx_arbiter #(.NumRx(NRX), .CellBytes(CB)) dut (
`endif
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .port_en_i     (en),
        .xfer_ack_i    (ack),
        .grant_o       (grant),
        .grant_id_o    (gid),
        .grant_valid_o (gvalid),
        .byte_idx_o    (bidx),
        .cell_done_o   (cdone),
        .timeout_err_o (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cell-level reference: who owns the path, how many bytes have moved,
    // and whether the one dead cycle after a completed cell is pending.
    int m_owner = -1;
    bit m_setup = 0;
    bit m_gap   = 0;
    int m_acks  = 0;
    int m_stall = 0;
    int m_ptr   = 0;
    bit e_done  = 0;
    bit e_terr  = 0;
    logic [15:0] m_elig;
    bit m_found;
    int m_p;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_owner = -1; m_setup = 0; m_gap = 0; m_acks = 0;
            m_stall = 0;  m_ptr = 0;   e_done = 0; e_terr = 0;
        end else begin
            e_done = 0;
            e_terr = 0;
            if (m_owner < 0) begin
                if (m_gap) begin
                    m_gap = 0;
                end else begin
                    m_elig  = req & en;
                    m_found = 0;
                    for (int k = 0; k < NRX; k++) begin
                        m_p = (m_ptr + k) % NRX;
                        if (!m_found && m_elig[4'(m_p)]) begin
                            m_found = 1; m_owner = m_p; m_setup = 1;
                            m_acks = 0;  m_stall = 0;
                        end
                    end
                end
            end else if (m_setup) begin
                m_setup = 0;
            end else if (ack) begin
                m_acks++;
                m_stall = 0;
                if (m_acks == CB) begin
                    e_done = 1; m_ptr = (m_owner + 1) % NRX;
                    m_owner = -1; m_gap = 1; m_acks = 0;
                end
            end else begin
                m_stall++;
                if (TO > 0 && m_stall == TO) begin
                    e_terr = 1; m_ptr = (m_owner + 1) % NRX;
                    m_owner = -1; m_acks = 0;
                end
            end
        end
    end

    // Per-cycle compare plus an event log of grant starts, completions, aborts.
    int gq[$];
    int gcyc[$];
    int dcyc[$];
    int tcyc[$];
    bit prev_valid = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        chk("grant_valid", 32'(gvalid), 32'(m_owner >= 0));
        chk("grant", 32'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
        if (m_owner >= 0) chk("grant_id", 32'(gid), m_owner);
        chk("byte_idx", 32'(bidx), (m_owner >= 0) ? m_acks : 0);
        chk("cell_done", 32'(cdone), 32'(e_done));
        chk("timeout_err", 32'(terr), 32'(e_terr));
        if (gvalid && !prev_valid) begin
            gq.push_back(int'(gid));
            gcyc.push_back(cyc);
        end
        if (cdone) dcyc.push_back(cyc);
        if (terr)  tcyc.push_back(cyc);
        prev_valid = gvalid;
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return gq.size();
            1:       return dcyc.size();
            default: return tcyc.size();
        endcase
    endfunction

    task automatic clear_q();
        gq.delete(); gcyc.delete(); dcyc.delete(); tcyc.delete();
    endtask

    task automatic wait_q(input int which, input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (qsize(which) >= n) break;
            @(negedge clk); #1;
        end
        chk(name, 32'(qsize(which) >= n), 1);
    endtask

    task automatic wait_byte(input int v, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (int'(bidx) == v && gvalid) break;
            @(negedge clk); #1;
        end
        chk(name, 32'(bidx), v);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"},       32'(grant),  0);
        chk({tag, "_grant_id"},    32'(gid),    0);
        chk({tag, "_grant_valid"}, 32'(gvalid), 0);
        chk({tag, "_byte_idx"},    32'(bidx),   0);
        chk({tag, "_cell_done"},   32'(cdone),  0);
        chk({tag, "_timeout_err"}, 32'(terr),   0);
    endtask

    int r0;
    int exp2[5];
    int exp3[5];
    int stall_len;

    initial begin
        rst = 1'b1; req = '0; en = '1; ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk); #1;

        // Single requester: 1-cycle grant latency, DONE on the 55th cycle of the cell.
        clear_q();
        req = 16'h0020;
        r0 = cyc;
        wait_q(0, 2, 300, "t1_grants");
        req = '0;
        wait_q(1, 2, 300, "t1_dones");
        chk("t1_id0", gq[0], 5);
        chk("t1_id1", gq[1], 5);
        chk("t1_latency", gcyc[0] - r0, 1);
        chk("t1_done_delay", dcyc[0] - gcyc[0], 54);
        chk("t1_regrant_gap", gcyc[1] - dcyc[0], 2);

        // Fairness: pointer sits at 6 after port 5, so 9 goes first; wraps after 15.
        clear_q();
        req = 16'h8204;
        wait_q(0, 5, 600, "t2_grants");
        req = '0;
        wait_q(1, 5, 600, "t2_dones");
        exp2 = '{9, 15, 2, 9, 15};
        for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), gq[k], exp2[k]);

        // Masking: only 0 and 7 eligible; disabling 7 mid-cell lets that cell finish.
        clear_q();
        req = '1;
        en  = 16'h0081;
        wait_q(0, 4, 600, "t3_grants4");
        repeat (10) @(negedge clk);
        #1;
        en = 16'h0001;
        wait_q(0, 5, 300, "t3_grants5");
        req = '0;
        en  = '1;
        wait_q(1, 5, 300, "t3_dones");
        exp3 = '{0, 7, 0, 7, 0};
        for (int k = 0; k < 5; k++) chk($sformatf("t3_order%0d", k), gq[k], exp3[k]);
        chk("t3_cell7_len", dcyc[3] - gcyc[3], 54);

        // Stall at byte 30; req dropped during the cell is ignored.
        clear_q();
        stall_len = (TO > 0) ? 10 : 100;
        req = 16'h0008;
        wait_q(0, 1, 100, "t4_grant");
        req = '0;
        wait_byte(30, 100, "t4_reach30");
        ack = 1'b0;
        repeat (stall_len) @(negedge clk);
        #1;
        chk("t4_hold30", 32'(bidx), 30);
        ack = 1'b1;
        r0 = cyc;
        wait_q(1, 1, 100, "t4_done");
        chk("t4_id", gq[0], 3);
        chk("t4_resume_to_done", dcyc[0] - r0, 23);

        // Reset mid-XFER at byte 20: immediate clear, no cell_done, pointer back to 0.
        clear_q();
        req = 16'h0010;
        wait_q(0, 1, 100, "t5_grant");
        wait_byte(20, 100, "t5_reach20");
        rst = 1'b1;
        #1;
        chk_zero("t5_async");
        req = 16'h00A0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        wait_q(0, 2, 100, "t5_regrant");
        req = '0;
        wait_q(1, 1, 100, "t5_done");
        chk("t5_first_id", gq[0], 4);
        chk("t5_after_reset_id", gq[1], 5);
        chk("t5_done_is_new_cell", dcyc[0] - gcyc[1], 54);

`ifdef UTOPIA_ARB_WATCHDOG_EN
        // Watchdog: 16 ack-less XFER cycles on port 3 abort the cell; 12 is next.
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        clear_q();
        req = 16'h1008;
        wait_q(0, 1, 100, "t6_grant");
        ack = 1'b0;
        wait_q(2, 1, 100, "t6_timeout");
        wait_q(0, 2, 100, "t6_next_grant");
        ack = 1'b1;
        req = '0;
        wait_q(1, 1, 100, "t6_done");
        chk("t6_first_id", gq[0], 3);
        chk("t6_timeout_delay", tcyc[0] - gcyc[0], 17);
        chk("t6_next_id", gq[1], 12);
        chk("t6_no_done_on_abort", dcyc[0] - gcyc[1], 54);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/utopia_rx_arbiter.md
Name: utopia_rx_arbiter

Overview:
- Round-robin scheduler that shares the single cell-forwarding path of the 16-port ATM switch among the 16 Utopia receive ports.
- Each Rx port controller raises a request when it holds a complete cell.
- The arbiter grants one port, paces the byte transfer of exactly one cell, then rotates priority.
- Sits between the Rx port controllers and the forwarding/lookup datapath; the per-port enable mask is driven from the management-interface registers.

Parameters:
- NumRx, 16, number of requesting receive ports (2..16).
- CellBytes, 53, bytes transferred per granted cell.
- TimeoutCycles, 1024, stall limit for the optional watchdog (power of two, at least 4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NumRx  per-port request; held high while the port has a cell pending.
- port_en  in  NumRx  per-port enable mask from the CPU registers. A disabled port is never granted.
- xfer_ack  in  1  datapath accepted one byte this cycle.
- grant  out  NumRx  one-hot grant; all zero when idle.
- grant_id  out  4  binary index of the granted port.
- grant_valid  out  1  a grant is active.
- byte_idx  out  6  index of the byte being transferred, 0..CellBytes-1.
- cell_done  out  1  one-cycle pulse after the last byte of a cell.
- timeout_err  out  1  one-cycle pulse on watchdog abort. Tied 0 when the optional feature is off.

Behaviour:
- Reset (asynchronous, rst=1):
  - grant=0, grant_id=0, grant_valid=0, byte_idx=0, cell_done=0, timeout_err=0.
  - Round-robin pointer=0; state=IDLE.
  - Asserting rst mid-transfer aborts immediately; no cell_done is produced.
- States: IDLE, GRANT, XFER, DONE.
- IDLE:
  - eligible = req & port_en.
  - If eligible is nonzero, pick the first set bit at or above the pointer, wrapping modulo NumRx.
  - Register grant/grant_id and go to GRANT. Latency from req to grant_valid is 1 cycle.
- GRANT:
  - grant_valid=1, byte_idx=0; unconditionally go to XFER next cycle (one-cycle setup for the datapath mux).
- XFER:
  - Each cycle with xfer_ack=1, byte_idx increments.
  - An ack at byte_idx=CellBytes-1 goes to DONE.
  - With xfer_ack=0, hold all outputs.
  - Deassertion of req or port_en during XFER is ignored; the cell always completes.
- DONE:
  - cell_done=1 for exactly one cycle; grant=0, grant_valid=0.
  - pointer = (grant_id+1) mod NumRx; go to IDLE.
  - A new arbitration is possible the following cycle, so back-to-back cells are 1 idle cycle apart.
- Boundaries:
  - Pointer wrap: when grant_id=NumRx-1, the next pointer is 0.
  - A single requester is re-granted each round.
  - xfer_ack is ignored outside XFER.
  - port_en changes take effect at the next IDLE evaluation.
  - If NumRx<16, grant_id upper bits are 0.

Optional Feature:
- Macro: UTOPIA_ARB_WATCHDOG_EN.
- With the macro defined:
  - A stall counter clears on every xfer_ack and counts XFER cycles without an ack.
  - On reaching TimeoutCycles: timeout_err pulses 1 cycle, cell_done is not pulsed, grant drops, the pointer advances past the stalled port, state returns to IDLE.
- Without the macro: no counter; timeout_err is constant 0, and XFER waits indefinitely.

Decomposition:
- Package squat_arb_pkg:
  - arb_state_t enum (IDLE, GRANT, XFER, DONE).
  - CELL_BYTES=53 constant.
  - port_id_t (logic [3:0]) typedef.
- One sub-module, rr_pick: combinational rotate-priority picker.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot, index, any.
  - Reused by the Tx-side scheduler.

Test Plan:
- Reset: assert rst for 3 cycles mid-XFER at byte_idx=20 -> all outputs 0 within the same cycle; after release the first grant goes to the lowest eligible port ≥0.
- Single port: req[5]=1, port_en=all ones, xfer_ack=1 continuously -> grant_id=5 one cycle after req; cell_done 55 cycles after grant_valid rises (1 GRANT + 53 XFER + DONE); re-grant to port 5.
- Fairness: req[2], req[9], req[15] held high with continuous ack -> grant order 2, 9, 15, 2, 9 …; pointer wraps after 15.
- Masking: req=0xFFFF, port_en=0x0081 -> only ports 0 and 7 granted, alternating; clearing port_en[7] mid-cell still completes the port 7 cell.
- Stall: xfer_ack low for 100 cycles at byte_idx=30 -> byte_idx holds at 30; after ack resumes, cell_done follows the 53rd ack.
- Watchdog (UTOPIA_ARB_WATCHDOG_EN, TimeoutCycles=16): no ack for 16 XFER cycles on port 3 -> timeout_err pulse, no cell_done, next grant goes to the next eligible port above 3.
